seq_arith_unit: RTL and testbench

//  Multi-cycle four-function arithmetic unit; successor to the single-cycle add/sub datapath.

---
 rtl/seq_arith_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_seq_arith_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_unit.sv
// ---------------------------------------------------------------------------
// seq_arith_unit
//
// Multi-cycle four-function arithmetic unit (add, sub, unsigned mul, unsigned
// div). Operands and opcode are captured on a Start request while idle. The
// result and condition codes appear together with a one-cycle Done pulse and
// hold until the next Done.
//
// Handshake: Start is a request that is sampled only while Busy=0. There is no
// queueing, so a Start seen while Busy=1 is dropped. Done is a single-cycle
// strobe. Rout and the flags are valid from the Done cycle on. Busy is already
// low in the Done cycle, so a Start held high in that cycle is accepted at the
// next edge.
//
// Ports
//   Clock     in   1        rising-edge clock
//   Reset     in   1        asynchronous, active-low reset
//   Start     in   1        operation request (sampled while idle)
//   Op        in   2        00 add, 01 sub, 10 mul, 11 div
//   A, B      in   WIDTH    operands (dividend / divisor for div)
//   Busy      out  1        operation in progress
//   Done      out  1        one-cycle completion pulse
//   Rout      out  2*WIDTH  result
//   OVR, NEG, ZERO, DivZero out 1  condition codes
//   dbg_state out  2        current FSM state (IDLE=0, ADDSUB=1, MUL=2, DIV=3)
// ---------------------------------------------------------------------------
module seq_arith_unit #(
    parameter int WIDTH = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Rout,
    output logic               OVR,
    output logic               NEG,
    output logic               ZERO,
    output logic               DivZero,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADDSUB = 2'd1,
        S_MUL    = 2'd2,
        S_DIV    = 2'd3
    } state_t;

    localparam int              CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    // Control
    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               sub_q,    sub_d;
    logic               dz_pend_q, dz_pend_d;

    // Operand / working registers
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplr_q,   mplr_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;

    // Visible results
    logic               done_q,   done_d;
    logic [2*WIDTH-1:0] rout_q,   rout_d;
    logic               ovr_q,    ovr_d;
    logic               neg_q,    neg_d;
    logic               zero_q,   zero_d;
    logic               divz_q,   divz_d;

    // Add/sub datapath: subtraction is a + ~b + 1.
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   addsub_r;
    logic               addsub_ovr;

    // One shift-add step
    logic [2*WIDTH-1:0] mul_acc_next;

    // One restoring-division step
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   div_rem_next;
    logic [WIDTH-1:0]   div_quo_next;

    always_comb begin
        b_eff      = sub_q ? ~b_q : b_q;
        addsub_r   = a_q + b_eff + {{(WIDTH-1){1'b0}}, sub_q};
        // Signed overflow: both adder inputs share a sign the result lacks.
        addsub_ovr = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                     (addsub_r[WIDTH-1] != a_q[WIDTH-1]);

        mul_acc_next = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

        // Bring the next dividend bit into the partial remainder, then try
        // to subtract the divisor. A borrow (MSB set) means restore.
        div_shift    = {rem_q, quo_q[WIDTH-1]};
        div_diff     = div_shift - {1'b0, b_q};
        div_rem_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_quo_next = {quo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sub_d     = sub_q;
        dz_pend_d = dz_pend_q;
        a_d       = a_q;
        b_d       = b_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        done_d    = 1'b0;
        rout_d    = rout_q;
        ovr_d     = ovr_q;
        neg_d     = neg_q;
        zero_d    = zero_q;
        divz_d    = divz_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_d       = A;
                    b_d       = B;
                    sub_d     = Op[0];
                    cnt_d     = '0;
                    mcand_d   = {{WIDTH{1'b0}}, A};
                    mplr_d    = B;
                    acc_d     = '0;
                    rem_d     = '0;
                    quo_d     = A;
                    dz_pend_d = (B == '0);
                    case (Op)
                        2'b10:   state_d = S_MUL;
                        2'b11:   state_d = S_DIV;
                        default: state_d = S_ADDSUB;
                    endcase
                end
            end

            S_ADDSUB: begin
                rout_d  = {{WIDTH{addsub_r[WIDTH-1]}}, addsub_r};
                ovr_d   = addsub_ovr;
                neg_d   = addsub_r[WIDTH-1];
                zero_d  = (addsub_r == '0);
                divz_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            S_MUL: begin
                acc_d   = mul_acc_next;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    rout_d  = mul_acc_next;
                    ovr_d   = |mul_acc_next[2*WIDTH-1:WIDTH];
                    neg_d   = 1'b0;
                    zero_d  = (mul_acc_next == '0);
                    divz_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_DIV: begin
                if (dz_pend_q) begin
                    // Divide by zero finishes in one step; quo_q still holds A.
                    rout_d  = {quo_q, {WIDTH{1'b1}}};
                    ovr_d   = 1'b1;
                    neg_d   = 1'b0;
                    zero_d  = 1'b0;
                    divz_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rem_d = div_rem_next;
                    quo_d = div_quo_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        rout_d  = {div_rem_next, div_quo_next};
                        ovr_d   = 1'b0;
                        neg_d   = 1'b0;
                        zero_d  = (div_quo_next == '0);
                        divz_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sub_q     <= 1'b0;
            dz_pend_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            done_q    <= 1'b0;
            rout_q    <= '0;
            ovr_q     <= 1'b0;
            neg_q     <= 1'b0;
            zero_q    <= 1'b0;
            divz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            dz_pend_q <= dz_pend_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            done_q    <= done_d;
            rout_q    <= rout_d;
            ovr_q     <= ovr_d;
            neg_q     <= neg_d;
            zero_q    <= zero_d;
            divz_q    <= divz_d;
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
    assign Rout      = rout_q;
    assign OVR       = ovr_q;
    assign NEG       = neg_q;
    assign ZERO      = zero_q;
    assign DivZero   = divz_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_arith_unit
//
// Testbench for seq_arith_unit at WIDTH=8. Each scenario lives in its own
// task and checks its own results. Expected values come from hard-coded
// constants or from ref_model. ref_model computes the results with plain
// integer arithmetic: a signed sum, a product, and a quotient/remainder.
// ---------------------------------------------------------------------------
module tb_seq_arith_unit;

    localparam int W = 8;

    logic           Clock = 1'b0;
    logic           Reset = 1'b0;
    logic           Start = 1'b0;
    logic [1:0]     Op    = 2'b00;
    logic [W-1:0]   A     = '0;
    logic [W-1:0]   B     = '0;
    logic           Busy;
    logic           Done;
    logic [2*W-1:0] Rout;
    logic           OVR;
    logic           NEG;
    logic           ZERO;
    logic           DivZero;
    logic [1:0]     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] last_rout = '0;

    seq_arith_unit #(.WIDTH(W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Rout      (Rout),
        .OVR       (OVR),
        .NEG       (NEG),
        .ZERO      (ZERO),
        .DivZero   (DivZero),
        .dbg_state (dbg_state)
    );

    always #5 Clock = ~Clock;

    // Flags are packed as {OVR, NEG, ZERO, DivZero}.
    function automatic void ref_model(input logic [1:0] op, input int a, input int b,
                                      output logic [2*W-1:0] r, output logic [3:0] flg,
                                      output int lat);
        int m, sa, sb, s, rr, p;
        m  = 1 << W;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        case (op)
            2'b00, 2'b01: begin
                s   = (op == 2'b00) ? sa + sb : sa - sb;
                rr  = ((s % m) + m) % m;
                r   = (rr >= m / 2) ? (2*W)'(rr + (m * m - m)) : (2*W)'(rr);
                flg = {(s > m / 2 - 1) || (s < -(m / 2)), rr >= m / 2, rr == 0, 1'b0};
                lat = 1;
            end
            2'b10: begin
                p   = a * b;
                r   = (2*W)'(p);
                flg = {p >= m, 1'b0, p == 0, 1'b0};
                lat = W;
            end
            default: begin
                if (b == 0) begin
                    r   = (2*W)'(a * m + (m - 1));
                    flg = 4'b1001;
                    lat = 1;
                end else begin
                    r   = (2*W)'((a % b) * m + (a / b));
                    flg = {1'b0, 1'b0, (a / b) == 0, 1'b0};
                    lat = W;
                end
            end
        endcase
    endfunction

    // Driver: issues one operation and waits (bounded) for Done.
    // lat = -1 on timeout. hold_ok clears if Rout moved before Done.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] hold_rout,
                          output logic [2*W-1:0] r, output logic [3:0] flg, output int lat,
                          output logic busy_at_done, output logic hold_ok);
        int cyc;
        cyc = 0;
        while (Busy === 1'b1 && cyc < 50) begin
            @(posedge Clock); #1;
            cyc++;
        end
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clock); #1;
        // Scramble inputs after capture; they must not matter.
        Start = 1'b0; Op = 2'($urandom); A = W'($urandom); B = W'($urandom);
        hold_ok = 1'b1;
        lat = -1;
        cyc = 0;
        while (cyc < 3 * W) begin
            @(posedge Clock); #1;
            cyc++;
            if (Done === 1'b1) begin
                lat = cyc;
                break;
            end
            if (Rout !== hold_rout) hold_ok = 1'b0;
        end
        r = Rout;
        flg = {OVR, NEG, ZERO, DivZero};
        busy_at_done = Busy;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if ({Busy, Done} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_done: got %b want 00", {Busy, Done});
        end
        checks++;
        if (Rout !== '0) begin
            errors++; $display("FAIL reset_rout: got %h want 0000", Rout);
        end
        checks++;
        if ({OVR, NEG, ZERO, DivZero} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {OVR, NEG, ZERO, DivZero});
        end
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        checks++;
        if ({Busy, Done} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle: got %b want 00", {Busy, Done});
        end
        last_rout = '0;
    endtask

    typedef struct packed {
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] r;
        logic [3:0]     flg;
        logic [3:0]     lat;
    } vec_t;

    task automatic test_directed();
        vec_t           v [9];
        logic [2*W-1:0] r;
        logic [3:0]     flg;
        int             lat;
        logic           bsy, hold;
        v[0] = '{2'd0, 8'h7F, 8'h01, 16'hFF80, 4'b1100, 4'd1};
        v[1] = '{2'd1, 8'h05, 8'h05, 16'h0000, 4'b0010, 4'd1};
        v[2] = '{2'd1, 8'h80, 8'h01, 16'h007F, 4'b1000, 4'd1};
        v[3] = '{2'd2, 8'hFF, 8'hFF, 16'hFE01, 4'b1000, 4'd8};
        v[4] = '{2'd3, 8'hC8, 8'h07, 16'h041C, 4'b0000, 4'd8};
        v[5] = '{2'd3, 8'h10, 8'h00, 16'h10FF, 4'b1001, 4'd1};
        v[6] = '{2'd0, 8'h03, 8'h04, 16'h0007, 4'b0000, 4'd1};
        v[7] = '{2'd2, 8'h00, 8'h5A, 16'h0000, 4'b0010, 4'd8};
        v[8] = '{2'd3, 8'h03, 8'h07, 16'h0300, 4'b0010, 4'd8};
        for (int i = 0; i < 9; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, last_rout, r, flg, lat, bsy, hold);
            checks++;
            if (lat !== int'(v[i].lat)) begin
                errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat);
            end
            checks++;
            if (r !== v[i].r) begin
                errors++; $display("FAIL dir%0d_rout: got %h want %h", i, r, v[i].r);
            end
            checks++;
            if (flg !== v[i].flg) begin
                errors++; $display("FAIL dir%0d_flags: got %b want %b", i, flg, v[i].flg);
            end
            checks++;
            if (bsy !== 1'b0 || hold !== 1'b1) begin
                errors++; $display("FAIL dir%0d_busy_hold: got busy=%b hold=%b want 0 1", i, bsy, hold);
            end
            last_rout = v[i].r;
        end
    endtask

    task automatic test_busy_ignore();
        int done_cnt, done_cyc;
        logic busy_ok;
        Start = 1'b1; Op = 2'b10; A = 8'hFF; B = 8'hFF;
        @(posedge Clock); #1;
        Start = 1'b0;
        done_cnt = 0; done_cyc = -1; busy_ok = 1'b1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge Clock); #1;
            if (cyc == 2) begin
                Start = 1'b1; Op = 2'b00; A = 8'h01; B = 8'h01;
            end
            if (cyc == 3) Start = 1'b0;
            if (Done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                checks++;
                if (Rout !== 16'hFE01 || OVR !== 1'b1) begin
                    errors++; $display("FAIL busy_ign_result: got %h ovr=%b want fe01 ovr=1", Rout, OVR);
                end
            end
            if (cyc < 8 && Busy !== 1'b1) busy_ok = 1'b0;
            if (cyc >= 8 && Busy !== 1'b0) busy_ok = 1'b0;
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 8) begin
            errors++; $display("FAIL busy_ign_done: got count=%0d at=%0d want 1 at 8", done_cnt, done_cyc);
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            errors++; $display("FAIL busy_ign_busy: got profile bad want busy t0+1..t0+7 only");
        end
        last_rout = 16'hFE01;
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        logic [2*W-1:0] r;
        logic [3:0] flg;
        int lat;
        logic bsy, hold;
        Start = 1'b1; Op = 2'b10; A = 8'hFF; B = 8'hFF;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        checks++;
        if ({Busy, Done, Rout, OVR, NEG, ZERO, DivZero} !== '0) begin
            errors++; $display("FAIL reset_mid_clear: got busy=%b done=%b rout=%h flags=%b want all 0",
                               Busy, Done, Rout, {OVR, NEG, ZERO, DivZero});
        end
        done_cnt = 0;
        repeat (12) begin
            @(posedge Clock); #1;
            if (Done === 1'b1) done_cnt++;
        end
        Reset = 1'b1;
        repeat (4) begin
            @(posedge Clock); #1;
            if (Done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++; $display("FAIL reset_mid_no_done: got %0d want 0", done_cnt);
        end
        last_rout = '0;
        run_op(2'b00, 8'h03, 8'h04, last_rout, r, flg, lat, bsy, hold);
        checks++;
        if (r !== 16'h0007 || lat !== 1 || hold !== 1'b1) begin
            errors++; $display("FAIL reset_mid_add: got %h lat=%0d hold=%b want 0007 1 1", r, lat, hold);
        end
        last_rout = 16'h0007;
    endtask

    task automatic test_back_to_back();
        int cyc, extra;
        Start = 1'b1; Op = 2'b10; A = 8'h03; B = 8'h05;
        @(posedge Clock); #1;
        // Start stays high; the ADD request must wait for the Done cycle.
        Op = 2'b00; A = 8'h22; B = 8'h11;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge Clock); #1;
            cyc++;
            if (Done === 1'b1) break;
        end
        checks++;
        if (cyc !== 8 || Rout !== 16'h000F || Busy !== 1'b0) begin
            errors++; $display("FAIL b2b_mul: got at=%0d rout=%h busy=%b want 8 000f 0", cyc, Rout, Busy);
        end
        @(posedge Clock); #1;
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", Busy, Done);
        end
        @(posedge Clock); #1;
        checks++;
        if (Done !== 1'b1 || Rout !== 16'h0033) begin
            errors++; $display("FAIL b2b_add: got done=%b rout=%h want 1 0033", Done, Rout);
        end
        extra = 0;
        repeat (4) begin
            @(posedge Clock); #1;
            if (Done === 1'b1 || Busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL b2b_no_dup: got %0d extra active cycles want 0", extra);
        end
        last_rout = 16'h0033;
    endtask

    task automatic test_random();
        logic [1:0]     op;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] r, er;
        logic [3:0]     flg, ef;
        int             lat, el, idle;
        logic           bsy, hold;
        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom_range(0, 255));
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
            ref_model(op, int'(a), int'(b), er, ef, el);
            run_op(op, a, b, last_rout, r, flg, lat, bsy, hold);
            checks++;
            if (lat !== el) begin
                errors++; $display("FAIL rnd%0d_latency op=%0d a=%h b=%h: got %0d want %0d", n, op, a, b, lat, el);
            end
            checks++;
            if (r !== er) begin
                errors++; $display("FAIL rnd%0d_rout op=%0d a=%h b=%h: got %h want %h", n, op, a, b, r, er);
            end
            checks++;
            if (flg !== ef) begin
                errors++; $display("FAIL rnd%0d_flags op=%0d a=%h b=%h: got %b want %b", n, op, a, b, flg, ef);
            end
            checks++;
            if (bsy !== 1'b0 || hold !== 1'b1) begin
                errors++; $display("FAIL rnd%0d_busy_hold: got busy=%b hold=%b want 0 1", n, bsy, hold);
            end
            last_rout = er;
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                @(posedge Clock); #1;
                checks++;
                if (Done !== 1'b0 || Busy !== 1'b0 || Rout !== er) begin
                    errors++; $display("FAIL rnd%0d_idle: got done=%b busy=%b rout=%h want 0 0 %h",
                                       n, Done, Busy, Rout, er);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
